xbus_arbiter: RTL and testbench

Blocking XBus interconnect for the Shenzhen I/O emulator, placed between the MCU cores of a design (designA/designB style top level) and shared by all of them. Every MCU port can post a write (`mov x, xN`) or a read (`mov xN, acc`). The block pairs one pending writer with one pending reader, copies the 11-bit value, and releases both with a one-cycle ack. Blocked ports stay blocked across time units, which gives XBus its rendezvous semantics. The block also provides the `slx` data-pending indication and a per-time-unit transfer count.

---
 rtl/shenzhen_pkg.sv | 19 +
 rtl/xbus_arbiter_rr_pick.sv | 37 +++
 rtl/xbus_arbiter.sv | 143 ++++++++++++++
 tb/tb_xbus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shenzhen_pkg.sv
// Shared definitions for the Shenzhen I/O emulator: XBus word width, value limits,
// the XBus arbiter FSM state type and a small index helper.
package shenzhen_pkg;

    localparam int unsigned XBUS_W   = 11;
    localparam int          XBUS_MIN = -999;
    localparam int          XBUS_MAX = 999;

    typedef enum logic {
        StIdle,
        StXfer
    } xbus_state_t;

    // Increment an index and wrap it back to zero at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xbus_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after start (wrapping modulo N),
// optionally skipping one excluded index.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic          excl_en,
    input  logic [IW-1:0] excl,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Scan N candidates starting at start; the first eligible one wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < int'(N); k++) begin
            sum = {1'b0, start} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand] && !(excl_en && (cand == excl))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Blocking XBus interconnect: pairs one pending writer with one pending reader
// (round-robin on both sides), copies the word and acks both in a single XFER cycle.
// Also provides the slx data-pending wake and per-time-unit transfer counts.
module xbus_arbiter
    import shenzhen_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = XBUS_W,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          posedge_big_clk,
    input  logic [NUM_PORTS-1:0]          wr_req,
    input  logic [NUM_PORTS*DATA_W-1:0]   wr_data,
    input  logic [NUM_PORTS-1:0]          rd_req,
    output logic [NUM_PORTS-1:0]          wr_ack,
    output logic [NUM_PORTS-1:0]          rd_ack,
    output logic [NUM_PORTS*DATA_W-1:0]   rd_data,
    output logic [NUM_PORTS-1:0]          data_pending,
    output logic [CNT_W-1:0]              xfer_count,
    output logic [CNT_W-1:0]              last_count
);

    localparam int unsigned IW = $clog2(NUM_PORTS);

    xbus_state_t state_q, state_d;

    logic [IW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [IW-1:0]               hold_w_q, hold_r_q;
    logic [DATA_W-1:0]           hold_data_q;
    logic [NUM_PORTS*DATA_W-1:0] rd_data_q;
    logic [CNT_W-1:0]            xfer_count_q, last_count_q;
    logic [CNT_W-1:0]            cnt_inc;

    logic [NUM_PORTS-1:0] rd_found;
    logic [IW-1:0]        rd_idx [NUM_PORTS];
    logic                 wr_found;
    logic [IW-1:0]        wr_idx;
    logic                 xfer_active;

    // One reader search per candidate writer, each excluding that writer.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd_pick
        rr_pick #(
            .N  (NUM_PORTS),
            .IW (IW)
        ) u_rd_pick (
            .req     (rd_req),
            .start   (rd_ptr_q),
            .excl_en (1'b1),
            .excl    (IW'(g)),
            .found   (rd_found[g]),
            .idx     (rd_idx[g])
        );
    end

    // Only writers that have a partner reader are candidates.
    rr_pick #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_wr_pick (
        .req     (wr_req & rd_found),
        .start   (wr_ptr_q),
        .excl_en (1'b0),
        .excl    ('0),
        .found   (wr_found),
        .idx     (wr_idx)
    );

    // Reset in the XFER cycle cancels the transfer, so it also gates the acks.
    assign xfer_active = (state_q == StXfer) && !reset;
    assign cnt_inc     = (&xfer_count_q) ? xfer_count_q : xfer_count_q + 1'b1;
    assign xfer_count  = xfer_count_q;
    assign last_count  = last_count_q;

    // Next-state: IDLE leaves on a found pair, XFER always lasts one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (wr_found) state_d = StXfer;
            StXfer:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Acks and the delivered word are presented together during XFER.
    always_comb begin
        wr_ack  = '0;
        rd_ack  = '0;
        rd_data = rd_data_q;
        if (xfer_active) begin
            wr_ack[hold_w_q] = 1'b1;
            rd_ack[hold_r_q] = 1'b1;
            rd_data[32'(hold_r_q)*DATA_W +: DATA_W] = hold_data_q;
        end
    end

    // slx wake: any writer other than the port itself.
    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            data_pending[i] = |(wr_req & ~(NUM_PORTS'(1) << i));
        end
    end

    // FSM, holding registers, round-robin pointers and delivered-word storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hold_w_q    <= '0;
            hold_r_q    <= '0;
            hold_data_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && wr_found) begin
                hold_w_q    <= wr_idx;
                hold_r_q    <= rd_idx[wr_idx];
                hold_data_q <= wr_data[32'(wr_idx)*DATA_W +: DATA_W];
            end
            if (state_q == StXfer) begin
                wr_ptr_q <= IW'(wrap_inc(32'(hold_w_q), NUM_PORTS));
                rd_ptr_q <= IW'(wrap_inc(32'(hold_r_q), NUM_PORTS));
                rd_data_q[32'(hold_r_q)*DATA_W +: DATA_W] <= hold_data_q;
            end
        end
    end

    // Transfer counters; a transfer on the time-unit boundary closes the old unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count_q <= '0;
            last_count_q <= '0;
        end else if (posedge_big_clk) begin
            last_count_q <= xfer_active ? cnt_inc : xfer_count_q;
            xfer_count_q <= '0;
        end else if (xfer_active) begin
            xfer_count_q <= cnt_inc;
        end
    end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Bench for xbus_arbiter: directed scenarios with literal expectations plus
// contract-respecting random traffic checked every cycle against a behavioural model.
module tb_xbus_arbiter;
    import shenzhen_pkg::*;

    localparam int N    = 4;
    localparam int W    = 11;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic             clk = 1'b0;
    logic             reset;
    logic             posedge_big_clk;
    logic [N-1:0]     wr_req, rd_req, wr_ack, rd_ack, data_pending;
    logic [N*W-1:0]   wr_data, rd_data;
    logic [CW-1:0]    xfer_count, last_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xbus_arbiter #(
        .NUM_PORTS (N),
        .DATA_W    (W),
        .CNT_W     (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .posedge_big_clk (posedge_big_clk),
        .wr_req          (wr_req),
        .wr_data         (wr_data),
        .rd_req          (rd_req),
        .wr_ack          (wr_ack),
        .rd_ack          (rd_ack),
        .rd_data         (rd_data),
        .data_pending    (data_pending),
        .xfer_count      (xfer_count),
        .last_count      (last_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] slot(input logic [N*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    // ---------------- behavioural model ----------------
    // A matched pair is remembered for one cycle, then delivered; pointers, stored
    // words and counts are plain integers.
    bit           m_pend;
    int           m_w, m_r, m_wp, m_rp, m_xc, m_lc;
    logic [W-1:0] m_pdata;
    logic [W-1:0] m_rd [N];

    task automatic model_clear();
        m_pend = 0; m_w = 0; m_r = 0; m_wp = 0; m_rp = 0; m_xc = 0; m_lc = 0;
        m_pdata = '0;
        for (int i = 0; i < N; i++) m_rd[i] = '0;
    endtask

    task automatic model_compare();
        logic [N-1:0] ew, er, edp;
        logic [W-1:0] ed;
        bit           live;
        live = m_pend && !reset;
        ew = '0; er = '0; edp = '0;
        if (live) begin
            ew[m_w] = 1'b1;
            er[m_r] = 1'b1;
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (j != i && wr_req[j]) edp[i] = 1'b1;
        chk("model wr_ack", 32'(wr_ack), 32'(ew));
        chk("model rd_ack", 32'(rd_ack), 32'(er));
        chk("model data_pending", 32'(data_pending), 32'(edp));
        for (int i = 0; i < N; i++) begin
            ed = (live && i == m_r) ? m_pdata : m_rd[i];
            chk("model rd_data", 32'(slot(rd_data, i)), 32'(ed));
        end
        chk("model xfer_count", 32'(xfer_count), 32'(m_xc));
        chk("model last_count", 32'(last_count), 32'(m_lc));
    endtask

    task automatic model_step();
        int  done;
        bit  got;
        int  w, r;
        done = 0;
        if (reset) begin
            model_clear();
        end else begin
            if (m_pend) begin
                m_rd[m_r] = m_pdata;
                m_wp = (m_w + 1) % N;
                m_rp = (m_r + 1) % N;
                m_pend = 0;
                done = 1;
            end else begin
                got = 0;
                for (int k = 0; k < N; k++) begin
                    w = (m_wp + k) % N;
                    if (!got && wr_req[w]) begin
                        for (int j = 0; j < N; j++) begin
                            r = (m_rp + j) % N;
                            if (!got && r != w && rd_req[r]) begin
                                got = 1; m_pend = 1; m_w = w; m_r = r;
                                m_pdata = slot(wr_data, w);
                            end
                        end
                    end
                end
            end
            if (posedge_big_clk) begin
                m_lc = (m_xc + done > CMAX) ? CMAX : m_xc + done;
                m_xc = 0;
            end else begin
                m_xc = (m_xc + done > CMAX) ? CMAX : m_xc + done;
            end
        end
    endtask

    initial model_clear();

    // Compare every cycle, then advance the model over the coming edge.
    always begin
        @(negedge clk);
        #2;
        model_compare();
        model_step();
    end

    // ---------------- stimulus ----------------
    task automatic do_xfer(input int w, input int r, input logic [W-1:0] d);
        bit got;
        got = 0;
        @(negedge clk);
        wr_data[w*W +: W] = d;
        wr_req[w] = 1'b1;
        rd_req[r] = 1'b1;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            #3;
            if (wr_ack[w] && rd_ack[r]) got = 1;
        end
        chk("do_xfer completed", 32'(got), 32'd1);
        @(negedge clk);
        wr_req[w] = 1'b0;
        rd_req[r] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] seen, la_w, la_r;
        logic [W-1:0] m999;
        int           grants[$], gcyc[$];
        int           exp_g[4];
        bit           got;
        int           v;

        reset = 1'b1; posedge_big_clk = 1'b0;
        wr_req = '0; rd_req = '0; wr_data = '0;
        @(negedge clk);
        #3;
        chk("reset xfer_count", 32'(xfer_count), 32'd0);
        chk("reset wr_ack", 32'(wr_ack), 32'd0);
        chk("reset rd_data", 32'(rd_data[31:0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Port 0 writes 42, port 2 reads.
        @(negedge clk);
        wr_data[0*W +: W] = 11'd42; wr_req = 4'b0001; rd_req = 4'b0100;
        #3 chk("t1 no ack in request cycle", 32'(wr_ack), 32'd0);
        @(negedge clk);
        #3;
        chk("t1 wr_ack", 32'(wr_ack), 32'h1);
        chk("t1 rd_ack", 32'(rd_ack), 32'h4);
        chk("t1 rd_data[2]", 32'(slot(rd_data, 2)), 32'd42);
        @(negedge clk);
        wr_req = '0; rd_req = '0;
        #3;
        chk("t1 xfer_count", 32'(xfer_count), 32'd1);
        chk("t1 rd_data[2] held", 32'(slot(rd_data, 2)), 32'd42);

        // Port 1 writes -999 with no reader for 50 cycles.
        m999 = -11'sd999;
        @(negedge clk);
        wr_data[1*W +: W] = m999; wr_req = 4'b0010;
        seen = '0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #3 seen = seen | wr_ack | rd_ack;
        end
        chk("t2 no acks while blocked", 32'(seen), 32'd0);
        chk("t2 data_pending", 32'(data_pending), 32'b1101);
        @(negedge clk);
        rd_req = 4'b1000;
        @(negedge clk);
        #3;
        chk("t2 wr_ack", 32'(wr_ack), 32'h2);
        chk("t2 rd_ack", 32'(rd_ack), 32'h8);
        chk("t2 rd_data[3]", 32'(slot(rd_data, 3)), 32'h419);
        @(negedge clk);
        wr_req = '0; rd_req = '0;

        // Writers 0,1,2 continuously to reader 3, from reset pointers.
        pulse_reset();
        wr_data[0*W +: W] = 11'd100; wr_data[1*W +: W] = 11'd101; wr_data[2*W +: W] = 11'd102;
        wr_req = 4'b0111; rd_req = 4'b1000;
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 0;
        for (int c = 0; c < 20 && grants.size() < 4; c++) begin
            @(negedge clk);
            #3;
            for (int i = 0; i < N; i++) begin
                if (wr_ack[i]) begin
                    grants.push_back(i);
                    gcyc.push_back(c);
                    chk("t3 delivered word", 32'(slot(rd_data, 3)), 32'(100 + i));
                end
            end
        end
        chk("t3 grant count", 32'(grants.size()), 32'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++) begin
            chk("t3 rotation", 32'(grants[k]), 32'(exp_g[k]));
            if (k > 0) chk("t3 grant spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd2);
        end
        @(negedge clk);
        wr_req = '0; rd_req = '0;

        // Port 2 both writes and reads: never pairs with itself.
        @(negedge clk);
        wr_data[2*W +: W] = 11'd77; wr_req = 4'b0100; rd_req = 4'b0100;
        seen = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #3 seen = seen | wr_ack | rd_ack;
        end
        chk("t4 no self transfer", 32'(seen), 32'd0);
        @(negedge clk);
        rd_req = 4'b0101;
        @(negedge clk);
        #3;
        chk("t4 wr_ack", 32'(wr_ack), 32'h4);
        chk("t4 rd_ack", 32'(rd_ack), 32'h1);
        chk("t4 rd_data[0]", 32'(slot(rd_data, 0)), 32'd77);
        @(negedge clk);
        wr_req = '0; rd_req = '0;

        // Fourth transfer of the unit lands on the time-unit boundary.
        pulse_reset();
        do_xfer(0, 1, 11'd5);
        do_xfer(0, 1, 11'd6);
        do_xfer(0, 1, 11'd7);
        #3 chk("t5 three transfers", 32'(xfer_count), 32'd3);
        @(negedge clk);
        wr_data[0*W +: W] = 11'd8; wr_req = 4'b0001; rd_req = 4'b0010;
        @(negedge clk);
        posedge_big_clk = 1'b1;
        #3 chk("t5 boundary ack", 32'(wr_ack), 32'h1);
        @(negedge clk);
        posedge_big_clk = 1'b0; wr_req = '0; rd_req = '0;
        #3;
        chk("t5 last_count", 32'(last_count), 32'd4);
        chk("t5 xfer_count", 32'(xfer_count), 32'd0);

        // Reset during XFER cancels the transfer; held requests complete later.
        @(negedge clk);
        wr_data[3*W +: W] = 11'd9; wr_req = 4'b1000; rd_req = 4'b0010;
        @(negedge clk);
        reset = 1'b1;
        #3;
        chk("t6 wr_ack suppressed", 32'(wr_ack), 32'd0);
        chk("t6 rd_ack suppressed", 32'(rd_ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #3;
        chk("t6 xfer_count cleared", 32'(xfer_count), 32'd0);
        chk("t6 last_count cleared", 32'(last_count), 32'd0);
        chk("t6 rd_data cleared", 32'(slot(rd_data, 1)), 32'd0);
        got = 0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            #3;
            if (wr_ack == 4'b1000 && rd_ack == 4'b0010) begin
                got = 1;
                chk("t6 rd_data[1]", 32'(slot(rd_data, 1)), 32'd9);
            end
        end
        chk("t6 retried transfer", 32'(got), 32'd1);
        @(negedge clk);
        wr_req = '0; rd_req = '0;

        // Random traffic: a long stretch without boundaries (drives saturation),
        // then boundaries and occasional resets.
        la_w = '0; la_r = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (la_w[i]) begin
                    wr_req[i] = 1'b0;
                end else if (!wr_req[i] && $urandom_range(0, 2) == 0) begin
                    v = XBUS_MIN + int'($urandom_range(0, XBUS_MAX - XBUS_MIN));
                    wr_data[i*W +: W] = W'(v);
                    wr_req[i] = 1'b1;
                end
                if (la_r[i]) begin
                    rd_req[i] = 1'b0;
                end else if (!rd_req[i] && $urandom_range(0, 2) == 0) begin
                    rd_req[i] = 1'b1;
                end
            end
            posedge_big_clk = (c >= 1200) && ($urandom_range(0, 15) == 0);
            reset           = (c >= 1200) && ($urandom_range(0, 299) == 0);
            #3;
            la_w = wr_ack;
            la_r = rd_ack;
        end
        @(negedge clk);
        reset = 1'b0; posedge_big_clk = 1'b0; wr_req = '0; rd_req = '0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
